// File: rtl/usr_pkg.sv
// Shared mode encodings and FSM state type for the universal shift register.
package usr_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/usr_op_unit.sv
// Combinational next-value function of the shift register for one operation.
// Latency: zero (pure logic); backpressure: none.
module usr_op_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
      MODE_LOAD: q_next = din;
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLR:  q_next = '0;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/param_universal_shift_register.sv
// Universal shift register with single-cycle ops (en) and counted bursts (start/busy/done).
// Latency: en op lands on the sampling edge; burst ops on E1..EN after start at E0; start is dropped while busy.
module param_universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [2:0]       mode_r;
  logic [CNT_W-1:0] remaining;
  logic [2:0]       op_mode;
  logic [WIDTH-1:0] q_next;

  // Bursts replay the latched mode; idle single ops use the live mode.
  assign op_mode = (state == RUN) ? mode_r : mode;

  usr_op_unit #(.WIDTH(WIDTH)) u_op (
    .q      (q),
    .mode   (op_mode),
    .din    (din),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q_next (q_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_r    <= MODE_HOLD;
      remaining <= '0;
      q         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              mode_r    <= mode;
              remaining <= count;
              state     <= RUN;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else if (en) begin
            q <= q_next;
          end
        end
        RUN: begin
          q         <= q_next;
          remaining <= remaining - 1'b1;
          if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed self-checking bench for param_universal_shift_register (WIDTH=8, CNT_W=4).
module tb_param_universal_shift_register;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] din;
  logic       sin_r;
  logic       sin_l;
  logic       start;
  logic [3:0] count;
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  param_universal_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .din    (din),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .start  (start),
    .count  (count),
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are observed on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; mode = 3'b011; din = v;
    step();
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 3'b000; din = 8'h00;
    sin_r = 1'b0; sin_l = 1'b0; start = 1'b0; count = 4'd0;
    #12;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done); end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL post_reset_q got=%h exp=00", q); end
  endtask

  task automatic test_single_ops();
    load(8'hA5);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL load got=%h exp=A5", q); end
    en = 1'b1; mode = 3'b001; sin_r = 1'b1;
    step();
    en = 1'b0; sin_r = 1'b0;
    checks++; if (q !== 8'hD2) begin errors++; $display("FAIL shr got=%h exp=D2", q); end
    checks++; if (sout_r !== 1'b0 || sout_l !== 1'b1) begin errors++; $display("FAIL sout got=%b%b exp=10", sout_l, sout_r); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_no_done got=%b exp=0", done); end
  endtask

  task automatic test_burst_rol();
    load(8'h81);
    start = 1'b1; mode = 3'b101; count = 4'd3;
    step();
    start = 1'b0; mode = 3'b000;
    checks++; if (q !== 8'h81 || busy !== 1'b1) begin errors++; $display("FAIL rol_e0 q=%h busy=%b exp=81/1", q, busy); end
    step();
    checks++; if (q !== 8'h03 || busy !== 1'b1) begin errors++; $display("FAIL rol_e1 q=%h busy=%b exp=03/1", q, busy); end
    step();
    checks++; if (q !== 8'h06 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rol_e2 q=%h busy=%b done=%b exp=06/1/0", q, busy, done); end
    step();
    checks++; if (q !== 8'h0C || busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL rol_e3 q=%h busy=%b done=%b exp=0C/0/1", q, busy, done); end
    step();
    checks++; if (done !== 1'b0 || q !== 8'h0C) begin errors++; $display("FAIL rol_after done=%b q=%h exp=0/0C", done, q); end
  endtask

  task automatic test_burst_asr();
    int dones;
    dones = 0;
    load(8'h90);
    start = 1'b1; mode = 3'b110; count = 4'd2; sin_r = 1'b0;
    step();
    start = 1'b0;
    step();
    checks++; if (q !== 8'hC8) begin errors++; $display("FAIL asr_e1 got=%h exp=C8", q); end
    step();
    checks++; if (q !== 8'hE4) begin errors++; $display("FAIL asr_e2 got=%h exp=E4", q); end
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) dones++;
      step();
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL asr_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_burst_shl_serial();
    load(8'h00);
    start = 1'b1; mode = 3'b010; count = 4'd4;
    step();
    start = 1'b0;
    sin_l = 1'b1; step();
    sin_l = 1'b0; step();
    sin_l = 1'b1; step();
    sin_l = 1'b1; step();
    sin_l = 1'b0;
    checks++; if (q !== 8'h0B || done !== 1'b1) begin errors++; $display("FAIL shl_serial q=%h done=%b exp=0B/1", q, done); end
  endtask

  task automatic test_zero_count_and_drop();
    int dones;
    int busy_seen;
    load(8'h3C);
    // en together with start: start wins, so no load happens.
    start = 1'b1; en = 1'b1; mode = 3'b011; din = 8'hFF; count = 4'd0;
    step();
    start = 1'b0; en = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h3C) begin errors++; $display("FAIL zero_count done=%b busy=%b q=%h exp=1/0/3C", done, busy, q); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_count_after done=%b busy=%b exp=0/0", done, busy); end
    start = 1'b1; mode = 3'b001; count = 4'd2; sin_r = 1'b0;
    step();
    start = 1'b1; mode = 3'b111; count = 4'd5;
    dones = 0; busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      start = 1'b0;
      if (done === 1'b1) dones++;
      if (busy === 1'b1) busy_seen++;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL drop_done_count got=%0d exp=1", dones); end
    checks++; if (q !== 8'h0F || busy !== 1'b0) begin errors++; $display("FAIL drop_final q=%h busy=%b exp=0F/0", q, busy); end
    checks++; if (busy_seen != 1) begin errors++; $display("FAIL drop_busy_cycles got=%0d exp=1", busy_seen); end
  endtask

  task automatic test_back_to_back();
    load(8'h01);
    start = 1'b1; mode = 3'b100; count = 4'd1;
    step();
    start = 1'b0;
    checks++; if (q !== 8'h01 || busy !== 1'b1) begin errors++; $display("FAIL b2b_e0 q=%h busy=%b exp=01/1", q, busy); end
    step();
    checks++; if (q !== 8'h80 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_e1 q=%h done=%b busy=%b exp=80/1/0", q, done, busy); end
    start = 1'b1; mode = 3'b100; count = 4'd1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || q !== 8'h80) begin errors++; $display("FAIL b2b_accept busy=%b done=%b q=%h exp=1/0/80", busy, done, q); end
    step();
    checks++; if (q !== 8'h40 || done !== 1'b1) begin errors++; $display("FAIL b2b_second q=%h done=%b exp=40/1", q, done); end
  endtask

  task automatic test_long_count();
    bit seen;
    load(8'hFF);
    start = 1'b1; mode = 3'b001; count = 4'd10; sin_r = 1'b0;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || q !== 8'h00) begin errors++; $display("FAIL shr_saturate seen=%b q=%h exp=1/00", seen, q); end
    load(8'h81);
    start = 1'b1; mode = 3'b101; count = 4'd9;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || q !== 8'h03) begin errors++; $display("FAIL rol_wrap seen=%b q=%h exp=1/03", seen, q); end
  endtask

  task automatic test_async_reset();
    int dones;
    bit seen;
    load(8'hAA);
    start = 1'b1; mode = 3'b010; count = 4'd5; sin_l = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    checks++; if (q !== 8'hA8 || busy !== 1'b1) begin errors++; $display("FAIL arst_pre q=%h busy=%b exp=A8/1", q, busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_now q=%h busy=%b done=%b exp=00/0/0", q, busy, done); end
    rst = 1'b0;
    @(negedge clk);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      step();
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL arst_quiet got=%0d exp=0", dones); end
    start = 1'b1; mode = 3'b011; din = 8'h5A; count = 4'd1;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || q !== 8'h5A) begin errors++; $display("FAIL arst_restart seen=%b q=%h exp=1/5A", seen, q); end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_burst_rol();
    test_burst_asr();
    test_burst_shl_serial();
    test_zero_count_and_drop();
    test_back_to_back();
    test_long_count();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
